// File: rtl/nco_ctrl_pkg.sv
// Shared constants, FSM state and config register layout for the NCO command controller.
package nco_ctrl_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   localparam logic [7:0] CMD_ICW      = 8'h01;
   localparam logic [7:0] CMD_QCW      = 8'h02;
   localparam logic [7:0] CMD_IPCW     = 8'h03;
   localparam logic [7:0] CMD_QPCW     = 8'h04;
   localparam logic [7:0] CMD_RFEN     = 8'h05;
   localparam logic [7:0] CMD_DEFAULTS = 8'h0F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DHI,
      ST_DLO,
      ST_CSUM
   } state_t;

   typedef struct packed {
      logic [15:0] i_cw;
      logic [15:0] q_cw;
      logic [15:0] i_pcw;
      logic [15:0] q_pcw;
      logic        rf_en;
   } cfg_t;

   function automatic logic cmd_valid(input logic [7:0] c);
      case (c)
         CMD_ICW, CMD_QCW, CMD_IPCW, CMD_QPCW, CMD_RFEN, CMD_DEFAULTS: cmd_valid = 1'b1;
         default:                                                      cmd_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter; holds at its terminal count once expired.
module frame_timer #(
   parameter int TIMEOUT_CYC = 40000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

   assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/nco_cmd_ctrl.sv
// Parses 5-byte UART command frames, updates the NCO config registers and queues ACK/NAK.
module nco_cmd_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int          TIMEOUT_CYC = 40000,
   parameter logic [15:0] I_CW_RST    = 16'h4000,
   parameter logic [15:0] Q_CW_RST    = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_dat,
   input  logic        rx_stb,
   input  logic        rx_err,
   input  logic        tx_busy,
   output logic [15:0] i_cw,
   output logic [15:0] q_cw,
   output logic [15:0] i_pcw,
   output logic [15:0] q_pcw,
   output logic        rf_en,
   output logic        cfg_stb,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  tx_dat,
   output logic        tx_stb
);

   localparam cfg_t CFG_RST = '{i_cw: I_CW_RST, q_cw: Q_CW_RST, i_pcw: 16'h0, q_pcw: 16'h0, rf_en: 1'b0};

   state_t     state_q, state_d;
   cfg_t       cfg_q;
   logic [7:0] cmd_q, dhi_q, dlo_q;
   logic       ack_pend;
   logic [7:0] ack_byte;

   logic tm_expired;
   logic byte_ok, abort;
   logic frm_good, frm_bad;
   logic lat_cmd, lat_dhi, lat_dlo;

   // rx_err beats a coincident byte; a coincident byte beats the timeout.
   assign byte_ok = rx_stb && !rx_err;
   assign abort   = (state_q != ST_IDLE) && (rx_err || (tm_expired && !rx_stb));

   frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (rx_stb || (state_q == ST_IDLE)),
      .en      (state_q != ST_IDLE),
      .expired (tm_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort)
         state_d = ST_IDLE;
      else if (byte_ok) begin
         case (state_q)
            ST_IDLE: if (rx_dat == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD:  state_d = ST_DHI;
            ST_DHI:  state_d = ST_DLO;
            ST_DLO:  state_d = ST_CSUM;
            ST_CSUM: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      lat_cmd  = 1'b0;
      lat_dhi  = 1'b0;
      lat_dlo  = 1'b0;
      frm_good = 1'b0;
      frm_bad  = abort;
      if (!abort && byte_ok) begin
         case (state_q)
            ST_CMD:  lat_cmd = 1'b1;
            ST_DHI:  lat_dhi = 1'b1;
            ST_DLO:  lat_dlo = 1'b1;
            ST_CSUM: begin
               if ((rx_dat == (cmd_q ^ dhi_q ^ dlo_q)) && cmd_valid(cmd_q))
                  frm_good = 1'b1;
               else
                  frm_bad = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q <= 8'h0;
         dhi_q <= 8'h0;
         dlo_q <= 8'h0;
      end else begin
         if (lat_cmd) cmd_q <= rx_dat;
         if (lat_dhi) dhi_q <= rx_dat;
         if (lat_dlo) dlo_q <= rx_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q     <= CFG_RST;
         cfg_stb   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cfg_stb   <= frm_good;
         frame_ok  <= frm_good;
         frame_err <= frm_bad;
         if (frm_good) begin
            case (cmd_q)
               CMD_ICW:      cfg_q.i_cw  <= {dhi_q, dlo_q};
               CMD_QCW:      cfg_q.q_cw  <= {dhi_q, dlo_q};
               CMD_IPCW:     cfg_q.i_pcw <= {dhi_q, dlo_q};
               CMD_QPCW:     cfg_q.q_pcw <= {dhi_q, dlo_q};
               CMD_RFEN:     cfg_q.rf_en <= dlo_q[0];
               CMD_DEFAULTS: cfg_q       <= CFG_RST;
               default:      ;
            endcase
         end
      end
   end

   // One-deep response slot: a newer response overwrites one still waiting on the UART.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_pend <= 1'b0;
         ack_byte <= 8'h0;
         tx_stb   <= 1'b0;
         tx_dat   <= 8'h0;
      end else begin
         tx_stb <= 1'b0;
         if (ack_pend && !tx_busy) begin
            tx_stb   <= 1'b1;
            tx_dat   <= ack_byte;
            ack_pend <= 1'b0;
         end
         if (frm_good || frm_bad) begin
            ack_pend <= 1'b1;
            ack_byte <= frm_good ? ACK_BYTE : NAK_BYTE;
         end
      end
   end

   assign i_cw  = cfg_q.i_cw;
   assign q_cw  = cfg_q.q_cw;
   assign i_pcw = cfg_q.i_pcw;
   assign q_pcw = cfg_q.q_pcw;
   assign rf_en = cfg_q.rf_en;

endmodule

// File: doc/nco_cmd_ctrl.md
# nco_cmd_ctrl

Serial command controller for the dual-NCO RF source. Consumes the byte stream from the UART receiver (`acia_rx`), parses fixed 5-byte frames, and updates the control and phase words of the I and Q NCOs plus an RF output enable. Each frame is answered with an ACK or NAK byte for the UART transmitter. It sits between `acia_rx` and the two `nco` instances in the same clock domain.

## Interface
- `TIMEOUT_CYC`, 40000: idle cycles allowed between bytes of one frame; 10 ms at 4 MHz.
- `I_CW_RST`, 16'h4000: reset value of `i_cw`.
- `Q_CW_RST`, 16'h0800: reset value of `q_cw`.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_dat`  in  8  received byte, valid while `rx_stb` is high.
- `rx_stb`  in  1  one-cycle byte-valid strobe.
- `rx_err`  in  1  one-cycle framing-error strobe from the receiver.
- `tx_busy`  in  1  transmitter busy; a byte is accepted only while this is low.
- `i_cw`, `q_cw`  out  16  NCO frequency control words.
- `i_pcw`, `q_pcw`  out  16  NCO phase control words.
- `rf_en`  out  1  RF output enable.
- `cfg_stb`  out  1  one-cycle pulse when any config register changes.
- `frame_ok`, `frame_err`  out  1  one-cycle frame status pulses.
- `tx_dat`  out  8  response byte.
- `tx_stb`  out  1  one-cycle transmit request.

## Operation
- Frame format: `0xA5`, CMD, DHI, DLO, CSUM. CSUM is CMD ^ DHI ^ DLO.
- Commands:
  - `0x01` sets `i_cw`; `0x02` sets `q_cw`; `0x03` sets `i_pcw`; `0x04` sets `q_pcw`. Each takes the value {DHI,DLO}.
  - `0x05` sets `rf_en` to DLO[0].
  - `0x0F` restores all config registers to their reset values.
  - Any other CMD is invalid.
- FSM states: IDLE, CMD, DHI, DLO, CSUM. Transitions happen only on `rx_stb`, except on abort.
  - IDLE: byte `0xA5` moves to CMD; any other byte is discarded silently.
  - CMD → DHI → DLO → CSUM: each byte is latched as it arrives.
  - In CSUM, the checksum byte returns the FSM to IDLE. If the checksum matches and CMD is valid, the command is applied, `frame_ok` pulses, and ACK `0x06` is queued. Otherwise `frame_err` pulses and NAK `0x15` is queued.
- Abort to IDLE, with `frame_err` pulse and NAK queued, in either case:
  - `rx_err` in any non-IDLE state;
  - timeout: the inter-byte counter reaches `TIMEOUT_CYC-1` in a non-IDLE state. The counter clears on every `rx_stb` and while in IDLE.
- `rx_err` in IDLE is ignored and produces no response.
- Response queue:
  - one-deep register: `ack_pend` plus `ack_byte`;
  - `tx_stb` asserts when `ack_pend` is high and `tx_busy` is low, and `ack_pend` clears in the same cycle;
  - a new response while `ack_pend` is high overwrites `ack_byte`;
  - the parser never stalls on the transmitter.
- `cfg_stb` pulses on every successfully applied frame, including writes of an unchanged value and `0x0F`.
- Reset values:
  - `i_cw`=`I_CW_RST`, `q_cw`=`Q_CW_RST`, `i_pcw`=0, `q_pcw`=0, `rf_en`=0;
  - all strobes 0, `tx_dat`=0, `ack_pend`=0, FSM=IDLE, timer=0.

## Timing
- Config registers, `cfg_stb` and `frame_ok` update on the edge after the cycle in which the CSUM `rx_stb` is sampled. Latency is 1 cycle.
- `frame_err` follows the terminating event (bad CSUM strobe, `rx_err`, or timeout) by 1 cycle.
- `tx_stb`/`tx_dat` appear no earlier than 1 cycle after the queued response, and later if `tx_busy` is high.
- Simultaneous `rx_stb` and `rx_err`: `rx_err` wins and the byte is dropped.
- Timeout and `rx_stb` in the same cycle: the byte wins and the timer clears.
- `rst` mid-frame: the partial frame is discarded, registers return to their reset values, and no response is sent.
- Back-to-back frames with zero gap are supported. A `0xA5` arriving in the cycle after CSUM starts a new frame.

## Structure
- Package `nco_ctrl_pkg` holds:
  - `SYNC_BYTE`=8'hA5, `ACK_BYTE`=8'h06, `NAK_BYTE`=8'h15;
  - command code constants `CMD_ICW`..`CMD_DEFAULTS`;
  - the FSM state typedef.
- Sub-module `frame_timer` is the inter-byte timeout counter, with inputs `clr` and `en` and output `expired`. Its width is `$clog2(TIMEOUT_CYC)`.
- Parser FSM, config registers and response queue live in `nco_cmd_ctrl`.

## Test plan
- Bytes A5 01 12 34 27 → `i_cw`=16'h1234, one `cfg_stb`, one `frame_ok`, `tx_dat`=0x06 with `tx_stb`; other registers unchanged.
- Bytes A5 02 12 34 00 (bad checksum) → `q_cw` stays 16'h0800, `frame_err` pulses, `tx_dat`=0x15.
- Bytes A5 05 00 01 04, then A5 0F 00 00 0F → `rf_en` goes 1, then all registers return to reset values; two ACKs.
- Bytes A5 03, then silence for `TIMEOUT_CYC` cycles → `frame_err` and NAK; then A5 03 80 00 83 → `i_pcw`=16'h8000.
- `tx_busy` held high across two complete frames (first good, second bad) → on release, exactly one `tx_stb` with `tx_dat`=0x15.
- `rx_err` pulsed on the DLO byte → abort with NAK. A stray 0x55 in IDLE → no response. `rst` asserted mid-frame → reset values restored and no `tx_stb`.
